// File: rtl/stopwatch_core.sv
// stopwatch_core: count-up mm:ss stopwatch engine driven by a sampled 1 kHz tick.
// Button levels and clk1k are edge-detected locally; outputs are registered.
// Optional lap-hold display is built only when STOPWATCH_LAP_EN is defined.
module stopwatch_core #(
  parameter int MS_PER_SEC = 1000,
  parameter int MAX_MIN    = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clk1k,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic       lap,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic       running,
  output logic       blink,
  output logic       overflow
);

  localparam int              MS_W     = (MS_PER_SEC > 1) ? $clog2(MS_PER_SEC) : 1;
  localparam logic [MS_W-1:0] MS_LAST  = MS_W'(MS_PER_SEC - 1);
  localparam logic [5:0]      MIN_LAST = 6'(MAX_MIN);
  localparam logic [5:0]      SEC_LAST = 6'd59;

`ifdef STOPWATCH_LAP_EN
  typedef enum logic [2:0] {IDLE, RUN, LAP, PAUSED, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, RUN, PAUSED, DONE} state_t;
`endif

  state_t          state_q, state_d;
  logic [MS_W-1:0] ms_q, ms_d;
  logic [5:0]      sec_q, sec_d;
  logic [5:0]      min_q, min_d;
  logic            ovf_q, ovf_d;

  // Previous-cycle copies of the sampled levels for rising-edge detection
  logic start_prev_q, stop_prev_q, clear_prev_q, clk1k_prev_q;

  // Registered display outputs
  logic [5:0] minutes_q, seconds_q;
  logic       running_q, blink_q, overflow_q;

  logic ev_start, ev_stop, ev_clear, ev_lap, ev_tick;
  logic counting;
  logic saturate;
  logic [5:0] disp_min, disp_sec;

  assign ev_start = start & ~start_prev_q;
  assign ev_stop  = stop  & ~stop_prev_q;
  assign ev_clear = clear & ~clear_prev_q;
  assign ev_tick  = clk1k & ~clk1k_prev_q;

`ifdef STOPWATCH_LAP_EN
  logic       lap_prev_q;
  logic [5:0] lap_min_q, lap_min_d;
  logic [5:0] lap_sec_q, lap_sec_d;

  assign ev_lap   = lap & ~lap_prev_q;
  assign counting = (state_q == RUN) || (state_q == LAP);
  assign disp_min = (state_q == LAP) ? lap_min_q : min_q;
  assign disp_sec = (state_q == LAP) ? lap_sec_q : sec_q;

  // Lap edge register and frozen lap value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lap_prev_q <= 1'b0;
      lap_min_q  <= '0;
      lap_sec_q  <= '0;
    end else begin
      lap_prev_q <= lap;
      if (en) begin
        lap_min_q <= lap_min_d;
        lap_sec_q <= lap_sec_d;
      end
    end
  end
`else
  // The lap button is not wired to anything in this build
  logic lap_unused;
  assign lap_unused = lap;
  assign ev_lap     = 1'b0;
  assign counting   = (state_q == RUN);
  assign disp_min   = min_q;
  assign disp_sec   = sec_q;
`endif

  // Edge registers track their inputs regardless of en, so levels that rise
  // while disabled never produce a late event
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_prev_q <= 1'b0;
      stop_prev_q  <= 1'b0;
      clear_prev_q <= 1'b0;
      clk1k_prev_q <= 1'b0;
    end else begin
      start_prev_q <= start;
      stop_prev_q  <= stop;
      clear_prev_q <= clear;
      clk1k_prev_q <= clk1k;
    end
  end

  // State and counter registers, frozen while en is low
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ms_q    <= '0;
      sec_q   <= '0;
      min_q   <= '0;
      ovf_q   <= 1'b0;
    end else if (en) begin
      state_q <= state_d;
      ms_q    <= ms_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state and counter logic: clear beats everything, then stop > start > lap
  always_comb begin
    state_d  = state_q;
    ms_d     = ms_q;
    sec_d    = sec_q;
    min_d    = min_q;
    ovf_d    = ovf_q;
    saturate = 1'b0;
`ifdef STOPWATCH_LAP_EN
    lap_min_d = lap_min_q;
    lap_sec_d = lap_sec_q;
`endif
    if (ev_clear) begin
      state_d = IDLE;
      ms_d    = '0;
      sec_d   = '0;
      min_d   = '0;
      ovf_d   = 1'b0;
`ifdef STOPWATCH_LAP_EN
      lap_min_d = '0;
      lap_sec_d = '0;
`endif
    end else begin
      if (counting && ev_tick) begin
        if (ms_q == MS_LAST) begin
          ms_d = '0;
          if (sec_q == SEC_LAST) begin
            if (min_q == MIN_LAST) begin
              // Hold at the top value instead of wrapping
              saturate = 1'b1;
              ovf_d    = 1'b1;
            end else begin
              sec_d = '0;
              min_d = min_q + 6'd1;
            end
          end else begin
            sec_d = sec_q + 6'd1;
          end
        end else begin
          ms_d = ms_q + 1'b1;
        end
      end

      case (state_q)
        IDLE: begin
          if (ev_start) state_d = RUN;
        end
        RUN: begin
          if (ev_stop) begin
            state_d = PAUSED;
          end else if (!ev_start && ev_lap) begin
`ifdef STOPWATCH_LAP_EN
            state_d   = LAP;
            lap_min_d = min_q;
            lap_sec_d = sec_q;
`endif
          end
        end
`ifdef STOPWATCH_LAP_EN
        LAP: begin
          if (ev_stop) begin
            state_d = PAUSED;
          end else if (ev_start) begin
            state_d = RUN;
          end else if (ev_lap) begin
            lap_min_d = min_q;
            lap_sec_d = sec_q;
          end
        end
`endif
        PAUSED: begin
          if (ev_start) state_d = RUN;
        end
        DONE: begin
          state_d = DONE;
        end
        default: state_d = IDLE;
      endcase

      // Saturation overrides any concurrent stop/lap decision
      if (saturate) state_d = DONE;
    end
  end

  // Output register stage, one clk behind the counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      minutes_q  <= '0;
      seconds_q  <= '0;
      running_q  <= 1'b0;
      blink_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else if (en) begin
      minutes_q  <= disp_min;
      seconds_q  <= disp_sec;
`ifdef STOPWATCH_LAP_EN
      running_q  <= (state_q == RUN) || (state_q == LAP);
`else
      running_q  <= (state_q == RUN);
`endif
      blink_q    <= (state_q == PAUSED) || (state_q == DONE);
      overflow_q <= ovf_q;
    end
  end

  assign minutes  = minutes_q;
  assign seconds  = seconds_q;
  assign running  = running_q;
  assign blink    = blink_q;
  assign overflow = overflow_q;

endmodule
